// File: rtl/ps2_mouse_host_seq.sv
// Host-side PS/2 mouse sequencer: runs the power-up command/response handshake
// over a byte-level PHY, then decodes 3-byte stream packets into button/motion outputs.
module ps2_mouse_host_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    output logic       tx_req,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_perr,
    output logic       ready,
    output logic       fail,
    output logic       pkt_valid,
    output logic       Click,
    output logic [2:0] btn,
    output logic [8:0] MagX,
    output logic [8:0] MagY,
    output logic [1:0] ovf,
    output logic [1:0] retries
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_TX_RST, S_W_ACK1, S_W_BAT, S_W_ID, S_TX_EN, S_W_ACK2, S_STREAM, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      b0_q, b0_d, b1_q, b1_d;
    logic            pend_q, pend_d, pend_perr_q, pend_perr_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic            tx_req_q, tx_req_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            ready_q, ready_d, fail_q, fail_d, pkt_q, pkt_d, click_q, click_d;
    logic [2:0]      btn_q, btn_d;
    logic [8:0]      magx_q, magx_d, magy_q, magy_d;
    logic [1:0]      ovf_q, ovf_d, retries_q, retries_d;

    logic            timeout, failure, resend, accept;
    logic            in_v, in_perr;
    logic [7:0]      in_data, expect_byte;

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_TX_RST;
            timer_q     <= '0;
            retry_q     <= '0;
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pend_q      <= 1'b0;
            pend_perr_q <= 1'b0;
            pend_data_q <= '0;
            tx_req_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            pkt_q       <= 1'b0;
            click_q     <= 1'b0;
            btn_q       <= '0;
            magx_q      <= '0;
            magy_q      <= '0;
            ovf_q       <= '0;
            retries_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            pend_q      <= pend_d;
            pend_perr_q <= pend_perr_d;
            pend_data_q <= pend_data_d;
            tx_req_q    <= tx_req_d;
            tx_data_q   <= tx_data_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            pkt_q       <= pkt_d;
            click_q     <= click_d;
            btn_q       <= btn_d;
            magx_q      <= magx_d;
            magy_q      <= magy_d;
            ovf_q       <= ovf_d;
            retries_q   <= retries_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        pend_d      = 1'b0;
        pend_perr_d = pend_perr_q;
        pend_data_d = pend_data_q;
        tx_req_d    = tx_req_q;
        tx_data_d   = tx_data_q;
        pkt_d       = 1'b0;
        click_d     = click_q;
        btn_d       = btn_q;
        magx_d      = magx_q;
        magy_d      = magy_q;
        ovf_d       = ovf_q;
        failure     = 1'b0;
        resend      = 1'b0;
        accept      = 1'b0;

        timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

        // A byte that arrived together with tx_done is replayed in the wait state
        in_v    = pend_q | rx_valid;
        in_data = pend_q ? pend_data_q : rx_data;
        in_perr = pend_q ? pend_perr_q : rx_perr;

        case (state_q)
            S_W_BAT: expect_byte = 8'hAA;
            S_W_ID:  expect_byte = 8'h00;
            default: expect_byte = 8'hFA;
        endcase

        case (state_q)
            S_TX_RST, S_TX_EN: begin
                if (tx_req_q && tx_err) begin
                    failure = 1'b1;
                end else if (tx_req_q && tx_done) begin
                    tx_req_d    = 1'b0;
                    state_d     = (state_q == S_TX_RST) ? S_W_ACK1 : S_W_ACK2;
                    pend_d      = rx_valid;
                    pend_data_d = rx_data;
                    pend_perr_d = rx_perr;
                end else if (!tx_req_q && !tx_busy) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = (state_q == S_TX_RST) ? 8'hFF : 8'hF4;
                end
            end
            S_W_ACK1, S_W_BAT, S_W_ID, S_W_ACK2: begin
                if (in_v) begin
                    if (!in_perr && in_data == expect_byte) begin
                        case (state_q)
                            S_W_ACK1: state_d = S_W_BAT;
                            S_W_BAT:  state_d = S_W_ID;
                            S_W_ID:   state_d = S_TX_EN;
                            default:  state_d = S_STREAM;
                        endcase
                    end else if (!in_perr && in_data == 8'hFE &&
                                 (state_q == S_W_ACK1 || state_q == S_W_ACK2)) begin
                        resend  = 1'b1;
                        state_d = (state_q == S_W_ACK1) ? S_TX_RST : S_TX_EN;
                    end else begin
                        failure = 1'b1;
                    end
                end else if (timeout) begin
                    failure = 1'b1;
                end
            end
            S_STREAM: begin
                if (rx_valid && rx_perr) begin
                    idx_d = 2'd0;
                end else if (rx_valid) begin
                    case (idx_q)
                        2'd0: begin
                            if (rx_data[3]) begin
                                b0_d   = rx_data;
                                idx_d  = 2'd1;
                                accept = 1'b1;
                            end
                        end
                        2'd1: begin
                            b1_d   = rx_data;
                            idx_d  = 2'd2;
                            accept = 1'b1;
                        end
                        default: begin
                            btn_d   = b0_q[2:0];
                            click_d = b0_q[0] | b0_q[1];
                            magx_d  = {b0_q[4], b1_q};
                            magy_d  = {b0_q[5], rx_data};
                            ovf_d   = {b0_q[7], b0_q[6]};
                            pkt_d   = 1'b1;
                            idx_d   = 2'd0;
                            accept  = 1'b1;
                        end
                    endcase
                end else if (idx_q != 2'd0 && timeout) begin
                    idx_d = 2'd0;
                end
            end
            default: begin
                tx_req_d = 1'b0;
            end
        endcase

        if (failure || resend) begin
            retry_d  = retry_q + RW'(1);
            tx_req_d = 1'b0;
            if (retry_d == RW'(MAX_RETRY)) begin
                state_d = S_FAIL;
            end else if (failure) begin
                state_d = S_TX_RST;
            end
        end

        if (state_d != state_q || failure || resend || accept) begin
            timer_d = '0;
        end else if (state_q != S_FAIL && !(state_q == S_STREAM && idx_q == 2'd0) && !timeout) begin
            timer_d = timer_q + TW'(1);
        end

        ready_d   = (state_d == S_STREAM);
        fail_d    = (state_d == S_FAIL);
        retries_d = (32'(retry_d) > 32'd3) ? 2'd3 : 2'(retry_d);
    end

    assign tx_req    = tx_req_q;
    assign tx_data   = tx_data_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign pkt_valid = pkt_q;
    assign Click     = click_q;
    assign btn       = btn_q;
    assign MagX      = magx_q;
    assign MagY      = magy_q;
    assign ovf       = ovf_q;
    assign retries   = retries_q;

endmodule

// File: doc/ps2_mouse_host_seq.md
Name: ps2_mouse_host_seq

Overview:
- Host-side sequencer for the PS/2 mouse link.
- Drives a byte-level PS/2 PHY (transmit/receive shifters on M_CLK/M_Dat) through power-up initialisation:
  - reset command, ACK, self-test, device ID
  - enable-reporting command, ACK
- Then assembles 3-byte stream packets into button and movement outputs.
- Sits between the PHY and the cursor/game logic, in the Clk domain only.

Parameters:
- TIMEOUT_CYCLES, 5000000: Clk cycles allowed per wait state (100 ms at 50 MHz); also the inter-byte timeout in stream mode.
- MAX_RETRY, 3: failed init attempts tolerated before entering FAIL.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Rst  input  1  synchronous, active-high reset.
- tx_req  output  1  request PHY to send tx_data; level, held until tx_done or tx_err.
- tx_data  output  8  command byte; stable while tx_req=1.
- tx_busy  input  1  PHY transmitter busy.
- tx_done  input  1  one-cycle pulse: byte sent and line ACK seen.
- tx_err  input  1  one-cycle pulse: transmit failed.
- rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  input  8  received byte.
- rx_perr  input  1  qualifies rx_valid: parity/framing error.
- ready  output  1  init complete, streaming.
- fail  output  1  init abandoned after MAX_RETRY attempts.
- pkt_valid  output  1  one-cycle pulse: new packet on outputs.
- Click  output  1  left OR right button of last packet.
- btn  output  3  {middle,right,left} of last packet.
- MagX  output  9  signed X delta {sign, byte1}.
- MagY  output  9  signed Y delta {sign, byte2}.
- ovf  output  2  {Y overflow, X overflow} of last packet.
- retries  output  2  failed-attempt count (saturating).

Behaviour:
- Reset: Rst=1 on a posedge → state TX_RST; every output 0; tx_data=8'h00; timer, retry count and byte index cleared. Rst mid-transfer aborts it: tx_req drops the next cycle.
- States, in order:
  - TX_RST: tx_data=FF.
  - W_ACK1: expects FA.
  - W_BAT: expects AA.
  - W_ID: expects 00.
  - TX_EN: tx_data=F4.
  - W_ACK2: expects FA.
  - STREAM.
  - FAIL.
- TX states:
  - Assert tx_req only when tx_busy=0, with tx_data set the same cycle.
  - tx_done → deassert tx_req next cycle and go to the following wait state.
  - tx_err → failure.
- Wait states:
  - rx_valid with rx_perr=0 and the expected byte → next state.
  - rx_data=FE in W_ACK1 or W_ACK2 → return to the preceding TX state (resend). Counts as a failure for retry counting but does not restart the sequence.
  - Any other byte, rx_perr=1, or the timer reaching TIMEOUT_CYCLES → failure.
- Failure handling: retry count +1. If the count equals MAX_RETRY → FAIL; otherwise → TX_RST.
- Timer: cleared on every state entry and every accepted byte; counts in every state except FAIL and idle STREAM (STREAM with index 0).
- W_ACK2 → STREAM: ready=1 from the first STREAM cycle; retry count is kept, not cleared.
- FAIL: fail=1, tx_req=0, rx ignored; exits only on Rst.
- STREAM packet assembly, byte index 0..2:
  - Index 0: accept the byte only if rx_data[3]=1; otherwise discard it and stay at 0 (resync).
  - Index 2 byte accepted: the cycle after its rx_valid, update btn, Click, MagX, MagY and ovf together and pulse pkt_valid for 1 cycle. Outputs hold between packets.
  - Field mapping:
    - btn = b0[2:0]; Click = b0[0] | b0[1]
    - MagX = {b0[4], b1}; MagY = {b0[5], b2}
    - ovf = {b0[7], b0[6]}
  - rx_perr=1 → drop the partial packet, index=0.
  - Inter-byte timeout (timer reaches TIMEOUT_CYCLES while index≠0) → index=0. No outputs change.
  - ready stays 1 in STREAM regardless of dropped packets.
- Simultaneous events:
  - tx_done and rx_valid in the same cycle: process tx_done first; the byte is evaluated in the new wait state.
  - tx_err and tx_done together: treat as tx_err.
  - rx_valid while in a TX state is ignored.

Test Plan:
- Normal init: Rst, then PHY returns tx_done; bytes FA, AA, 00; tx_done; FA → tx_data sequence FF then F4; ready=1 one cycle after the last FA; retries=0, fail=0.
- Packet decode: in STREAM send 09,05,FB → one pkt_valid pulse; btn=001, Click=1, MagX=+5 (0_05), MagY=0_FB, ovf=00.
  - Then send 38,10,20 → MagX=1_10, MagY=1_20, Click=0.
- Resync: in STREAM send 00 (bit3=0), then 08,01,02 → the 00 is discarded; exactly one pkt_valid with MagX=0_01, MagY=0_02.
- Resend/timeout: respond FE to the first FF → FF retransmitted, retries=1. Then withhold all bytes → after TIMEOUT_CYCLES the sequence restarts at TX_RST, retries=2.
- Fail: force tx_err on 3 consecutive attempts (MAX_RETRY=3) → fail=1, tx_req stays 0, ready=0; Rst clears everything and FF is sent again.
- Mid-op reset and partial-packet drop: in STREAM send 08,01 then rx_perr → no pkt_valid. Then assert Rst while tx_req=1 in TX_EN → all outputs 0 next cycle and the sequence restarts at TX_RST.
